// File: rtl/qc_row_syndrome_accumulator_if.sv
// Bus between the circular shifter / sequencer and the row syndrome accumulator.
// The frame_weight signal exists only when QC_ROW_WEIGHT_CNT_EN is defined.
interface qc_row_syndrome_accumulator_if #(
    parameter int MAXZ     = 81,
    parameter int NUM_ROWS = 12
);
    localparam int ZW = $clog2(MAXZ + 1);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int WW = $clog2(NUM_ROWS * MAXZ + 1);

    logic            frame_start;
    logic [ZW-1:0]   z_size;
    logic            valid_in;
    logic [MAXZ-1:0] in_data;
    logic            row_last;
    logic            valid_out;
    logic [MAXZ-1:0] out_data;
    logic [RW-1:0]   out_row;
    logic            frame_done;
    logic            frame_ok;
    logic            deg_err;
`ifdef QC_ROW_WEIGHT_CNT_EN
    logic [WW-1:0]   frame_weight;

    modport master (
        output frame_start, z_size, valid_in, in_data, row_last,
        input  valid_out, out_data, out_row, frame_done, frame_ok, deg_err, frame_weight
    );
    modport slave (
        input  frame_start, z_size, valid_in, in_data, row_last,
        output valid_out, out_data, out_row, frame_done, frame_ok, deg_err, frame_weight
    );
`else
    modport master (
        output frame_start, z_size, valid_in, in_data, row_last,
        input  valid_out, out_data, out_row, frame_done, frame_ok, deg_err
    );
    modport slave (
        input  frame_start, z_size, valid_in, in_data, row_last,
        output valid_out, out_data, out_row, frame_done, frame_ok, deg_err
    );
`endif
endinterface

// File: rtl/qc_row_syndrome_accumulator.sv
// XOR-accumulates rotated sub-blocks per QC-LDPC check-row, emits row syndromes and a frame verdict.
// Optional QC_ROW_WEIGHT_CNT_EN adds a per-frame popcount of all row syndromes (frame_weight).
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no frame open; valid_in/row_last ignored
// S_ACCUM | accumulating blocks of rows 0..NUM_ROWS-1
module qc_row_syndrome_accumulator #(
    parameter int MAXZ        = 81,
    parameter int NUM_ROWS    = 12,
    parameter int MAX_ROW_DEG = 8
) (
    input logic CLK,
    input logic rst,
    qc_row_syndrome_accumulator_if.slave bus
);
    localparam int ZW = $clog2(MAXZ + 1);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int DW = $clog2(MAX_ROW_DEG + 1);
    localparam int WW = $clog2(NUM_ROWS * MAXZ + 1);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [MAXZ-1:0] r_acc;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_deg;
    logic            r_fail;
    logic [ZW-1:0]   r_z;

    logic [ZW-1:0]   w_z_in;
    logic [ZW-1:0]   w_z_eff;
    logic [MAXZ-1:0] w_mask;
    logic [MAXZ-1:0] w_acc_nxt;
    logic [RW-1:0]   w_row_eff;
    logic [DW-1:0]   w_deg_eff;
    logic            w_fail_nxt;
    logic            w_take;
    logic            w_close;
    logic            w_last_row;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // frame_start overrides the frame state in the same cycle, so a beat
    // arriving with it is treated as the first block of row 0.
    always_comb begin
        w_z_in      = ((bus.z_size == '0) || (bus.z_size > ZW'(MAXZ))) ? ZW'(MAXZ) : bus.z_size;
        w_z_eff     = bus.frame_start ? w_z_in : r_z;
        w_row_eff   = bus.frame_start ? '0 : r_row;
        w_deg_eff   = bus.frame_start ? '0 : r_deg;
        w_mask      = '0;
        for (int i = 0; i < MAXZ; i++) begin
            w_mask[i] = (ZW'(i) < w_z_eff);
        end
        w_acc_nxt   = (w_deg_eff == '0) ? (bus.in_data & w_mask) : (r_acc ^ (bus.in_data & w_mask));
        w_fail_nxt  = (bus.frame_start ? 1'b0 : r_fail) | (|w_acc_nxt);
        w_take      = bus.valid_in && (bus.frame_start || (r_state == S_ACCUM));
        w_close     = w_take && bus.row_last;
        w_last_row  = (w_row_eff == RW'(NUM_ROWS - 1));

        w_state_nxt = r_state;
        if (bus.frame_start)        w_state_nxt = S_ACCUM;
        if (w_close && w_last_row)  w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bus.valid_out  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_row    <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_ok   <= 1'b0;
            bus.deg_err    <= 1'b0;
            r_acc          <= '0;
            r_row          <= '0;
            r_deg          <= '0;
            r_fail         <= 1'b0;
            r_z            <= ZW'(MAXZ);
        end else begin
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.frame_start) begin
                r_z          <= w_z_in;
                r_acc        <= '0;
                r_row        <= '0;
                r_deg        <= '0;
                r_fail       <= 1'b0;
                bus.frame_ok <= 1'b0;
                bus.deg_err  <= 1'b0;
            end
            if (w_take) begin
                if (w_deg_eff == DW'(MAX_ROW_DEG)) bus.deg_err <= 1'b1;
                if (w_close) begin
                    bus.out_data  <= w_acc_nxt;
                    bus.out_row   <= w_row_eff;
                    bus.valid_out <= 1'b1;
                    r_acc         <= '0;
                    r_deg         <= '0;
                    if (w_last_row) begin
                        bus.frame_done <= 1'b1;
                        bus.frame_ok   <= ~w_fail_nxt;
                        r_row          <= '0;
                        r_fail         <= 1'b0;
                    end else begin
                        r_row  <= w_row_eff + RW'(1);
                        r_fail <= w_fail_nxt;
                    end
                end else begin
                    r_acc <= w_acc_nxt;
                    // saturate so an over-long row cannot wrap back to "first block"
                    r_deg <= (w_deg_eff == DW'(MAX_ROW_DEG)) ? w_deg_eff : w_deg_eff + DW'(1);
                end
            end
        end
    end

`ifdef QC_ROW_WEIGHT_CNT_EN
    logic [WW-1:0] r_wsum;
    logic [WW-1:0] w_wsum_eff;
    logic [WW-1:0] w_pop;

    always_comb begin
        w_wsum_eff = bus.frame_start ? '0 : r_wsum;
        w_pop      = WW'($countones(w_acc_nxt));
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wsum           <= '0;
            bus.frame_weight <= '0;
        end else begin
            if (bus.frame_start) begin
                r_wsum           <= '0;
                bus.frame_weight <= '0;
            end
            if (w_close) begin
                if (w_last_row) begin
                    bus.frame_weight <= w_wsum_eff + w_pop;
                    r_wsum           <= '0;
                end else begin
                    r_wsum <= w_wsum_eff + w_pop;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_qc_row_syndrome_accumulator.sv
// Self-checking bench for qc_row_syndrome_accumulator (NUM_ROWS=2, MAXZ=81, MAX_ROW_DEG=8).
// Expected syndromes come from a row-level model: XOR of masked blocks per row.
module tb_qc_row_syndrome_accumulator;
    localparam int MAXZ = 81;
    localparam int NROWS = 2;
    localparam int MAXDEG = 8;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    qc_row_syndrome_accumulator_if #(.MAXZ(MAXZ), .NUM_ROWS(NROWS)) bus ();

    qc_row_syndrome_accumulator #(.MAXZ(MAXZ), .NUM_ROWS(NROWS), .MAX_ROW_DEG(MAXDEG)) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [MAXZ-1:0] cur_mask;
    bit              m_fail;
    bit              m_degerr;
    int              m_weight;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MAXZ-1:0] fmask(input int z);
        logic [MAXZ-1:0] ones;
        int zz;
        ones = '1;
        zz = (z == 0 || z > MAXZ) ? MAXZ : z;
        return ones >> (MAXZ - zz);
    endfunction

    function automatic logic [MAXZ-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[MAXZ-1:0];
    endfunction

    task automatic beat(input bit fs, input bit v, input bit last, input logic [MAXZ-1:0] d, input int z);
        bus.frame_start = fs;
        bus.valid_in    = v;
        bus.row_last    = last;
        bus.in_data     = d;
        bus.z_size      = 7'(z);
        @(posedge CLK);
        #1;
        bus.frame_start = 1'b0;
        bus.valid_in    = 1'b0;
        bus.row_last    = 1'b0;
        bus.in_data     = '0;
        bus.z_size      = '0;
    endtask

    task automatic idle();
        beat(0, 0, 1'($urandom_range(0, 1)), rnd(), 0);
        chk("idle_vout", bus.valid_out, 0);
    endtask

    task automatic start_frame(input int z);
        beat(1, 0, 0, '0, z);
        cur_mask = fmask(z);
        m_fail = 0;
        m_degerr = 0;
        m_weight = 0;
        chk("fs_vout", bus.valid_out, 0);
        chk("fs_degerr", bus.deg_err, 0);
        chk("fs_ok", bus.frame_ok, 0);
`ifdef QC_ROW_WEIGHT_CNT_EN
        chk("fs_weight", bus.frame_weight, 0);
`endif
    endtask

    task automatic close_checks(input logic [MAXZ-1:0] e, input int ridx, input bit lastrow);
        m_fail = m_fail | (e != '0);
        m_weight += $countones(e);
        chk("row_vout", bus.valid_out, 1);
        chk("row_data", bus.out_data, e);
        chk("row_idx", bus.out_row, ridx);
        chk("row_fdone", bus.frame_done, lastrow);
        chk("row_degerr", bus.deg_err, m_degerr);
        chk("row_ok", bus.frame_ok, lastrow ? !m_fail : 1'b0);
`ifdef QC_ROW_WEIGHT_CNT_EN
        if (lastrow) chk("frame_weight", bus.frame_weight, m_weight);
`endif
    endtask

    task automatic send_row(input logic [MAXZ-1:0] blk[$], input int ridx, input bit lastrow, input bit gaps);
        logic [MAXZ-1:0] e;
        e = '0;
        for (int i = 0; i < blk.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            e ^= blk[i] & cur_mask;
            if (i >= MAXDEG) m_degerr = 1;
            beat(0, 1, i == blk.size() - 1, blk[i], 0);
            if (i < blk.size() - 1) begin
                chk("blk_vout", bus.valid_out, 0);
                chk("blk_degerr", bus.deg_err, m_degerr);
            end
        end
        close_checks(e, ridx, lastrow);
    endtask

    initial begin
        logic [MAXZ-1:0] q[$];
        logic [MAXZ-1:0] a, b, c;
        bus.frame_start = 0; bus.valid_in = 0; bus.row_last = 0; bus.in_data = '0; bus.z_size = '0;
        cur_mask = '1; m_fail = 0; m_degerr = 0; m_weight = 0;

        // reset and idle behaviour
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("rst_vout", bus.valid_out, 0);
            chk("rst_data", bus.out_data, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 1, rnd(), 0);
            chk("idle_vout0", bus.valid_out, 0);
            chk("idle_data0", bus.out_data, 0);
            chk("idle_row0", bus.out_row, 0);
            chk("idle_fdone0", bus.frame_done, 0);
            chk("idle_ok0", bus.frame_ok, 0);
            chk("idle_deg0", bus.deg_err, 0);
        end

        // zero-syndrome frame
        start_frame(81);
        a = rnd(); b = rnd();
        q = '{a, a}; send_row(q, 0, 0, 0);
        q = '{b, b}; send_row(q, 1, 1, 0);
        beat(0, 1, 1, rnd(), 0);
        chk("post_frame_ignored", bus.valid_out, 0);
        chk("ok_holds", bus.frame_ok, 1);

        // nonzero row syndrome
        start_frame(81);
        q = '{81'h1, 81'h3}; send_row(q, 0, 0, 0);
        chk("nz_direct", bus.out_data, 81'h2);
        q = '{b, b}; send_row(q, 1, 1, 0);

        // masking with z=27
        start_frame(27);
        q = '{{MAXZ{1'b1}}}; send_row(q, 0, 0, 0);
        chk("mask27_direct", bus.out_data, {54'b0, {27{1'b1}}});
        q = '{rnd(), rnd()}; send_row(q, 1, 1, 0);

        // z=0 treated as full width, back-to-back single-block rows
        start_frame(0);
        q = '{rnd()}; send_row(q, 0, 0, 0);
        q = '{rnd()}; send_row(q, 1, 1, 0);

        // degree overflow: 9 blocks, then an exactly-8 row stays clean
        start_frame(81);
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(rnd());
        send_row(q, 0, 0, 0);
        q = '{rnd(), rnd()}; send_row(q, 1, 1, 0);
        chk("degerr_sticky", bus.deg_err, 1);
        start_frame(81);
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(rnd());
        send_row(q, 0, 0, 0);
        q = '{rnd()}; send_row(q, 1, 1, 0);

        // mid-frame frame_start carrying a single-block row
        start_frame(81);
        q = '{rnd(), rnd()}; send_row(q, 0, 0, 0);
        beat(0, 1, 0, rnd(), 0);
        c = rnd();
        beat(1, 1, 1, c, 81);
        cur_mask = fmask(81); m_fail = 0; m_degerr = 0; m_weight = 0;
        close_checks(c, 0, 0);
        q = '{rnd(), rnd(), rnd()}; send_row(q, 1, 1, 0);

        // random frames with idle gaps
        for (int f = 0; f < 8; f++) begin
            start_frame($urandom_range(0, 127));
            for (int r = 0; r < NROWS; r++) begin
                int n;
                n = $urandom_range(1, 9);
                q = {};
                for (int i = 0; i < n; i++) q.push_back(($urandom_range(0, 2) == 0) ? 81'h0 : rnd());
                if ($urandom_range(0, 2) == 0) q = '{q[0], q[0]};
                send_row(q, r, r == NROWS - 1, 1);
            end
        end

        // async reset mid-row
        start_frame(81);
        q = '{81'h5}; send_row(q, 0, 0, 0);
        beat(0, 1, 0, rnd(), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_vout", bus.valid_out, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_row", bus.out_row, 0);
        chk("arst_ok", bus.frame_ok, 0);
        chk("arst_deg", bus.deg_err, 0);
        @(posedge CLK); #1;
        rst = 1'b0;
        beat(0, 1, 1, rnd(), 0);
        chk("arst_idle", bus.valid_out, 0);
        start_frame(81);
        q = '{rnd()}; send_row(q, 0, 0, 0);
        q = '{rnd()}; send_row(q, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
